// File: rtl/input_debounce_sync.sv
// Pad input conditioner: synchronizer chain, stability-count debounce,
// registered edge pulses and an accepted-transition counter.
module input_debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_in,
  input  logic       en,
  input  logic       clr_count,
  output logic       d_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] edge_count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  logic                   differ;
  logic                   accept;

  assign synced = sync[SYNC_STAGES-1];
  assign differ = en & (synced != d_out);
  assign accept = differ & (cnt == LAST);

  // raw_in is read only here; the chain runs regardless of en
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      d_out      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (en) begin
        if (!differ) begin
          cnt <= '0;
        end else if (accept) begin
          cnt        <= '0;
          d_out      <= synced;
          rise_pulse <= synced;
          fall_pulse <= ~synced;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // clear wins over a coincident increment
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_count <= 8'd0;
    end else if (clr_count) begin
      edge_count <= 8'd0;
    end else if (accept) begin
      edge_count <= edge_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_input_debounce_sync.sv
// Scoreboard bench for input_debounce_sync (SYNC_STAGES=2, STABLE_CYCLES=4).
// Stimulus queues expected pulses; a monitor pops them as pulses appear.
module tb_input_debounce_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_in;
  logic       en;
  logic       clr_count;
  logic       d_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] edge_count;

  typedef struct {
    int         cyc;
    logic       rise;
    logic [7:0] cnt;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] mc = 8'd0;

  input_debounce_sync #(
    .SYNC_STAGES(2),
    .STABLE_CYCLES(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_in(raw_in),
    .en(en),
    .clr_count(clr_count),
    .d_out(d_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // clean step: visible on d_out 6 edges after the first sampling edge
  task automatic step(input logic v);
    exp_t e;
    raw_in = v;
    mc = mc + 8'd1;
    e.cyc = cyc + 6;
    e.rise = v;
    e.cnt = mc;
    q.push_back(e);
    tick(8);
  endtask

  // monitor: pops one expectation per observed pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rise_pulse || fall_pulse) begin
        if (q.size() == 0) begin
          chk("spurious_pulse", 1, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("rise_pulse", int'(rise_pulse), int'(e.rise));
          chk("fall_pulse", int'(fall_pulse), int'(!e.rise));
          chk("pulse_d_out", int'(d_out), int'(e.rise));
          chk("pulse_count", int'(edge_count), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    raw_in = 1'b0;
    en = 1'b1;
    clr_count = 1'b0;
    tick(2);
    chk("reset_d_out", int'(d_out), 0);
    chk("reset_rise", int'(rise_pulse), 0);
    chk("reset_fall", int'(fall_pulse), 0);
    chk("reset_count", int'(edge_count), 0);
    rst = 1'b0;
    tick(3);

    step(1'b1);
    chk("rise_level", int'(d_out), 1);
    chk("rise_count", int'(edge_count), 1);

    raw_in = 1'b0;
    tick(2);
    raw_in = 1'b1;
    tick(10);
    chk("bounce_low_level", int'(d_out), 1);
    chk("bounce_low_count", int'(edge_count), 1);

    step(1'b0);
    chk("fall_level", int'(d_out), 0);
    chk("fall_count", int'(edge_count), 2);

    raw_in = 1'b1;
    tick(2);
    raw_in = 1'b0;
    tick(10);
    chk("bounce_high_level", int'(d_out), 0);
    chk("bounce_high_count", int'(edge_count), 2);

    en = 1'b0;
    raw_in = 1'b1;
    tick(1);
    raw_in = 1'b0;
    tick(1);
    raw_in = 1'b1;
    tick(10);
    chk("frozen_level", int'(d_out), 0);
    chk("frozen_count", int'(edge_count), 2);
    en = 1'b1;
    mc = mc + 8'd1;
    e.cyc = cyc + 4;
    e.rise = 1'b1;
    e.cnt = mc;
    q.push_back(e);
    tick(6);
    chk("resume_level", int'(d_out), 1);

    for (int i = 0; i < 253; i++) step(~raw_in);
    chk("wrap_count", int'(edge_count), 0);
    chk("wrap_level", int'(d_out), 0);

    step(1'b1);
    chk("post_wrap_count", int'(edge_count), 1);

    raw_in = 1'b0;
    mc = 8'd0;
    e.cyc = cyc + 6;
    e.rise = 1'b0;
    e.cnt = 8'd0;
    q.push_back(e);
    tick(5);
    clr_count = 1'b1;
    tick(1);
    clr_count = 1'b0;
    tick(4);
    chk("clr_coincident", int'(edge_count), 0);
    chk("clr_level", int'(d_out), 0);

    raw_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midreset_d_out", int'(d_out), 0);
    chk("midreset_count", int'(edge_count), 0);
    mc = 8'd1;
    e.cyc = cyc + 6;
    e.rise = 1'b1;
    e.cnt = mc;
    q.push_back(e);
    tick(10);
    chk("reaccept_level", int'(d_out), 1);
    chk("reaccept_count", int'(edge_count), 1);

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
